sign_extender: RTL and testbench

- Registered sign/zero extender that widens an IN_W-bit two's-complement field to OUT_W bits.
- The output updates once per sysclk rising edge.
- Used in the datapath to widen short immediates and auxiliary fields, e.g. a 3-bit aux field to an 8-bit operand, before the ALU and register file.
- Adds a valid qualifier and a zero-extend mode, so one block serves both signed and unsigned fields.

---
 rtl/sign_extender_pkg.sv | 28 ++
 rtl/sign_extender_if.sv | 34 +++
 rtl/sign_extender.sv | 53 +++++
 tb/tb_sign_extender.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sign_extender_pkg.sv
// Shared widths and the reference extend function for the sign/zero extender.
// sext() is the one definition of the extend rule, used by the RTL.
package sign_extender_pkg;

    localparam int unsigned SE_IN_W_DEF  = 3;
    localparam int unsigned SE_OUT_W_DEF = 8;
    localparam int unsigned SE_MAX_W     = 64;
    localparam int unsigned SE_IDX_W     = $clog2(SE_MAX_W);

    typedef logic [SE_MAX_W-1:0] se_word_t;
    typedef logic [SE_IDX_W-1:0] se_idx_t;

    // Bits below in_w pass through; bits at and above in_w replicate the field MSB
    // when msb_en is set and are zero otherwise. in_w must be >= 1.
    function automatic se_word_t sext(input se_word_t value,
                                      input int unsigned in_w,
                                      input logic msb_en);
        se_word_t r;
        logic     fill;
        fill = msb_en & value[SE_IDX_W'(in_w - 1)];
        r    = '0;
        for (int unsigned i = 0; i < SE_MAX_W; i++) begin
            r[SE_IDX_W'(i)] = (i < in_w) ? value[SE_IDX_W'(i)] : fill;
        end
        return r;
    endfunction

endpackage

// File: rtl/sign_extender_if.sv
// Field-in / extended-result-out bundle of the sign extender.
interface sign_extender_if
    import sign_extender_pkg::*;
#(
    parameter int unsigned IN_W  = SE_IN_W_DEF,
    parameter int unsigned OUT_W = SE_OUT_W_DEF
);

    logic [IN_W-1:0]  aux;
    logic             zext;
    logic             in_valid;
    logic [OUT_W-1:0] signextended;
    logic             out_valid;
    logic             is_neg;

    modport master (
        output aux,
        output zext,
        output in_valid,
        input  signextended,
        input  out_valid,
        input  is_neg
    );

    modport slave (
        input  aux,
        input  zext,
        input  in_valid,
        output signextended,
        output out_valid,
        output is_neg
    );

endinterface

// File: rtl/sign_extender.sv
// Registered sign/zero extender: widens an IN_W-bit field to OUT_W bits with
// one cycle of latency and a one-cycle valid pulse per captured input.
module sign_extender
    import sign_extender_pkg::*;
#(
    parameter int unsigned IN_W  = SE_IN_W_DEF,
    parameter int unsigned OUT_W = SE_OUT_W_DEF
) (
    input  logic           sysclk,
    input  logic           rst_n,
    sign_extender_if.slave bus
);

    if (IN_W < 1 || OUT_W < IN_W || OUT_W > SE_MAX_W) begin : g_bad_width
        $fatal(1, "sign_extender: need 1 <= IN_W <= OUT_W <= %0d", SE_MAX_W);
    end

    logic [OUT_W-1:0] w_ext;
    logic             w_is_neg;

    logic [OUT_W-1:0] r_signextended;
    logic             r_out_valid;
    logic             r_is_neg;

    // Going through sext() keeps OUT_W == IN_W free of zero-width replications.
    always_comb begin
        w_is_neg = bus.aux[IN_W-1] & ~bus.zext;
        w_ext    = OUT_W'(sext(SE_MAX_W'(bus.aux), IN_W, ~bus.zext));
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_signextended <= '0;
            r_out_valid    <= 1'b0;
            r_is_neg       <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_signextended <= w_ext;
                r_is_neg       <= w_is_neg;
            end
        end
    end

    assign bus.signextended = r_signextended;
    assign bus.out_valid    = r_out_valid;
    assign bus.is_neg       = r_is_neg;

    a_in_valid_known: assert property (
        @(posedge sysclk) disable iff (!rst_n) !$isunknown(bus.in_valid)
    ) else $error("sign_extender: in_valid is X/Z");

endmodule

// File: tb/tb_sign_extender.sv
// Self-checking bench: four width configurations driven together, checked
// against an arithmetic model of sign/zero extension with one cycle of delay.
module tb_sign_extender;
    import sign_extender_pkg::*;

    logic sysclk;
    logic rst_n;

    sign_extender_if #(.IN_W(3), .OUT_W(8))  if_a ();
    sign_extender_if #(.IN_W(1), .OUT_W(8))  if_b ();
    sign_extender_if #(.IN_W(8), .OUT_W(8))  if_c ();
    sign_extender_if #(.IN_W(4), .OUT_W(16)) if_d ();

    sign_extender #(.IN_W(3), .OUT_W(8))  u_dut_a (.sysclk(sysclk), .rst_n(rst_n), .bus(if_a));
    sign_extender #(.IN_W(1), .OUT_W(8))  u_dut_b (.sysclk(sysclk), .rst_n(rst_n), .bus(if_b));
    sign_extender #(.IN_W(8), .OUT_W(8))  u_dut_c (.sysclk(sysclk), .rst_n(rst_n), .bus(if_c));
    sign_extender #(.IN_W(4), .OUT_W(16)) u_dut_d (.sysclk(sysclk), .rst_n(rst_n), .bus(if_d));

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    localparam int NI = 4;
    int in_w_t  [NI] = '{3, 1, 8, 4};
    int out_w_t [NI] = '{8, 8, 8, 16};

    logic [63:0] drv_aux [NI];
    logic        drv_z   [NI];
    logic        drv_v   [NI];
    logic [63:0] exp_val [NI];
    logic        exp_v   [NI];
    logic        exp_n   [NI];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Two's-complement widening done arithmetically: a negative field of value
    // a - 2^in_w becomes a - 2^in_w + 2^out_w modulo 2^out_w.
    function automatic logic [63:0] ref_ext(input logic [63:0] a, input int in_w,
                                            input int out_w, input logic z);
        if (!z && a >= (64'd1 << (in_w - 1)))
            return a + (64'd1 << out_w) - (64'd1 << in_w);
        return a;
    endfunction

    function automatic logic ref_neg(input logic [63:0] a, input int in_w, input logic z);
        return !z && (a >= (64'd1 << (in_w - 1)));
    endfunction

    task automatic drive(input int k, input logic [63:0] a, input logic z, input logic v);
        drv_aux[k] = a;
        drv_z[k]   = z;
        drv_v[k]   = v;
        case (k)
            0: begin if_a.aux = 3'(a); if_a.zext = z; if_a.in_valid = v; end
            1: begin if_b.aux = 1'(a); if_b.zext = z; if_b.in_valid = v; end
            2: begin if_c.aux = 8'(a); if_c.zext = z; if_c.in_valid = v; end
            default: begin if_d.aux = 4'(a); if_d.zext = z; if_d.in_valid = v; end
        endcase
    endtask

    task automatic idle_all();
        for (int k = 0; k < NI; k++) drive(k, drv_aux[k], drv_z[k], 1'b0);
    endtask

    function automatic logic [63:0] obs_val(input int k);
        case (k)
            0: return 64'(if_a.signextended);
            1: return 64'(if_b.signextended);
            2: return 64'(if_c.signextended);
            default: return 64'(if_d.signextended);
        endcase
    endfunction

    function automatic logic obs_v(input int k);
        case (k)
            0: return if_a.out_valid;
            1: return if_b.out_valid;
            2: return if_c.out_valid;
            default: return if_d.out_valid;
        endcase
    endfunction

    function automatic logic obs_n(input int k);
        case (k)
            0: return if_a.is_neg;
            1: return if_b.is_neg;
            2: return if_c.is_neg;
            default: return if_d.is_neg;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            exp_val[k] = '0;
            exp_v[k]   = 1'b0;
            exp_n[k]   = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("%s_i%0d_val", tag, k), obs_val(k), exp_val[k]);
            chk($sformatf("%s_i%0d_vld", tag, k), 64'(obs_v(k)), 64'(exp_v[k]));
            chk($sformatf("%s_i%0d_neg", tag, k), 64'(obs_n(k)), 64'(exp_n[k]));
        end
    endtask

    // One clock: advance the model on the rising edge, compare on the falling edge.
    task automatic cycle(input string tag);
        @(posedge sysclk);
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int k = 0; k < NI; k++) begin
                exp_v[k] = drv_v[k];
                if (drv_v[k]) begin
                    exp_val[k] = ref_ext(drv_aux[k], in_w_t[k], out_w_t[k], drv_z[k]);
                    exp_n[k]   = ref_neg(drv_aux[k], in_w_t[k], drv_z[k]);
                end
            end
        end
        @(negedge sysclk);
        check_all(tag);
    endtask

    task automatic step0(input string tag, input logic [63:0] a, input logic z,
                         input logic [63:0] want, input logic want_neg);
        idle_all();
        drive(0, a, z, 1'b1);
        cycle(tag);
        chk({tag, "_const"}, obs_val(0), want);
        chk({tag, "_negc"}, 64'(obs_n(0)), 64'(want_neg));
        chk({tag, "_vldc"}, 64'(obs_v(0)), 64'd1);
    endtask

    initial begin
        rst_n = 1'b1;
        for (int k = 0; k < NI; k++) drive(k, '0, 1'b0, 1'b0);
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_all("rst_async");

        // Reset held: a valid input must not reach the outputs.
        drive(0, 64'h7, 1'b0, 1'b1);
        repeat (3) cycle("rst_hold");
        chk("rst_hold_zero", obs_val(0), 64'h0);
        rst_n = 1'b1;

        step0("sx_100", 64'h4, 1'b0, 64'hFC, 1'b1);
        step0("sx_000", 64'h0, 1'b0, 64'h00, 1'b0);
        step0("sx_111", 64'h7, 1'b0, 64'hFF, 1'b1);
        step0("sx_010", 64'h2, 1'b0, 64'h02, 1'b0);
        step0("zx_100", 64'h4, 1'b1, 64'h04, 1'b0);
        step0("zx_111", 64'h7, 1'b1, 64'h07, 1'b0);

        // Hold: value and is_neg stay, out_valid drops.
        step0("hold_cap", 64'h5, 1'b0, 64'hFD, 1'b1);
        idle_all();
        drive(0, 64'h2, 1'b0, 1'b0);
        cycle("hold");
        chk("hold_val", obs_val(0), 64'hFD);
        chk("hold_vld", 64'(obs_v(0)), 64'd0);

        idle_all();
        drive(1, 64'h1, 1'b0, 1'b1);
        drive(2, 64'h80, 1'b0, 1'b1);
        drive(3, 64'h9, 1'b0, 1'b1);
        cycle("sweep");
        chk("w1_sx_one", obs_val(1), 64'hFF);
        chk("w8_80", obs_val(2), 64'h80);
        chk("w8_80_neg", 64'(obs_n(2)), 64'd1);
        chk("w4_16_9", obs_val(3), 64'hFFF9);

        idle_all();
        drive(1, 64'h1, 1'b1, 1'b1);
        drive(3, 64'h9, 1'b1, 1'b1);
        cycle("sweep_z");
        chk("w1_zx_one", obs_val(1), 64'h01);
        chk("w4_16_9_zx", obs_val(3), 64'h0009);

        chk("pkg_sext_neg", sext(64'h4, 3, 1'b1), 64'hFFFF_FFFF_FFFF_FFFC);
        chk("pkg_sext_z", sext(64'h4, 3, 1'b0), 64'h4);

        // Reset mid-cycle: outputs clear before the next rising edge.
        for (int k = 0; k < NI; k++) drive(k, 64'(in_w_t[k] == 1 ? 1 : 3), 1'b0, 1'b1);
        cycle("pre_midrst");
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all("midrst_async");
        repeat (2) cycle("midrst_hold");
        rst_n = 1'b1;
        idle_all();
        cycle("post_rst_idle");

        for (int n = 0; n < 1000; n++) begin
            for (int k = 0; k < NI; k++) begin
                logic [63:0] mask;
                mask = (64'd1 << in_w_t[k]) - 64'd1;
                drive(k, 64'($urandom) & mask, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3) != 0);
            end
            cycle("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
